// File: rtl/max_pool_2x2_pkg.sv
// Shared types and helpers for the 2x2 / stride-2 max-pool stage.
// Geometry stays per-instance; only sample width default and compare live here.
package max_pool_2x2_pkg;

    localparam int DW_DEF = 9;
    localparam int SMAX_W = 32;

    typedef enum logic {
        TOP    = 1'b0,
        BOTTOM = 1'b1
    } pool_state_e;

    // Callers sign-extend narrower samples to SMAX_W and truncate the result.
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_pool_line_buffer.sv
// Single-port half-row store for the top-row pair maxima.
// Registered write, combinational read, no reset: maps to distributed RAM.
module pool_line_buffer #(
    parameter int DW    = 9,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order conv sample stream.
// Emits one registered pooled value per window, one cycle after its last sample.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int RELU  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] pxl_in,
    output logic [DW-1:0] pool_out,
    output logic          valid,
    output logic          frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    pool_state_e          state;
    logic signed [DW-1:0] pair_reg;

    logic signed [DW-1:0] pxl_s;
    logic signed [DW-1:0] top_max;
    logic signed [DW-1:0] win_max;
    logic signed [DW-1:0] pooled;
    logic signed [DW-1:0] lb_rdata;
    logic [DW-1:0]        lb_rdata_raw;
    logic [AW-1:0]        lb_addr;
    logic                 lb_we;
    logic                 last_col;
    logic                 last_row;

    assign pxl_s    = pxl_in;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col >> 1);
    assign lb_we    = in_valid && (state == TOP) && col[0];
    assign lb_rdata = lb_rdata_raw;

    // top_max doubles as the bottom-row pair maximum in BOTTOM.
    assign top_max = DW'(smax(SMAX_W'(pair_reg), SMAX_W'(pxl_s)));
    assign win_max = DW'(smax(SMAX_W'(lb_rdata), SMAX_W'(top_max)));
    assign pooled  = ((RELU != 0) && (win_max < 0)) ? '0 : win_max;

    pool_line_buffer #(
        .DW    (DW),
        .DEPTH (HALF_W),
        .AW    (AW)
    ) u_lbuf (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_addr),
        .wdata (top_max),
        .rdata (lb_rdata_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            state      <= TOP;
            pair_reg   <= '0;
            pool_out   <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (last_col) begin
                    col   <= '0;
                    row   <= last_row ? '0 : row + 1'b1;
                    state <= (state == TOP) ? BOTTOM : TOP;
                end else begin
                    col <= col + 1'b1;
                end
                unique case (1'b1)
                    !col[0]: begin
                        pair_reg <= pxl_s;
                    end
                    col[0] && (state == BOTTOM): begin
                        pool_out   <= pooled;
                        valid      <= 1'b1;
                        frame_done <= last_row && last_col;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench: 4x4 instances (RELU 0/1) plus a default 26x26 instance,
// checked against a frame-array reference model with exact output timing.
module tb_max_pool_2x2;

    typedef struct {
        int         cyc;
        logic [8:0] val;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]      iv = '0;
    logic [1:0][8:0] px = '0;
    logic [2:0]      vld;
    logic [2:0]      fdn;
    logic [2:0][8:0] po;

    max_pool_2x2 #(.DW(9), .IMG_W(4), .IMG_H(4), .RELU(0)) u_a0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .pxl_in(px[0]),
        .pool_out(po[0]), .valid(vld[0]), .frame_done(fdn[0])
    );

    max_pool_2x2 #(.DW(9), .IMG_W(4), .IMG_H(4), .RELU(1)) u_a1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .pxl_in(px[0]),
        .pool_out(po[1]), .valid(vld[1]), .frame_done(fdn[1])
    );

    max_pool_2x2 u_b (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .pxl_in(px[1]),
        .pool_out(po[2]), .valid(vld[2]), .frame_done(fdn[2])
    );

    exp_t       expq [3][$];
    logic [8:0] obs  [3][$];
    int         fdcnt [3];
    int         pos [2];
    int         fbuf [2][676];
    int         frame [$];
    int         ev [$];
    int         checks = 0;
    int         failures = 0;

    function automatic void chk(bit ok, string name, int act, int expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    // Monitor: pops the scoreboard whenever an instance presents valid.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) begin
                    obs[i].push_back(po[i]);
                    if (fdn[i]) fdcnt[i]++;
                    if (expq[i].size() == 0) begin
                        chk(1'b0, $sformatf("u%0d unexpected valid", i),
                            int'($signed(po[i])), 0);
                    end else begin
                        exp_t e;
                        e = expq[i].pop_front();
                        chk(po[i] == e.val, $sformatf("u%0d pool_out", i),
                            int'($signed(po[i])), int'($signed(e.val)));
                        chk(fdn[i] == e.fd, $sformatf("u%0d frame_done", i),
                            int'(fdn[i]), int'(e.fd));
                        chk(cyc == e.cyc, $sformatf("u%0d latency", i),
                            cyc, e.cyc);
                    end
                end else begin
                    if (fdn[i])
                        chk(1'b0, $sformatf("u%0d frame_done w/o valid", i), 1, 0);
                    while (expq[i].size() > 0 && expq[i][0].cyc < cyc) begin
                        chk(1'b0, $sformatf("u%0d missing valid", i),
                            0, int'($signed(expq[i][0].val)));
                        void'(expq[i].pop_front());
                    end
                end
            end
        end
    end

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Reference: keep the whole frame, pool each window when it completes.
    task automatic drive(int g, int v, int gap);
        int w, r, c, p, m;
        exp_t e;
        w = (g != 0) ? 26 : 4;
        repeat (gap) begin
            @(posedge clk); #1;
            iv[g] = 1'b0;
        end
        @(posedge clk); #1;
        iv[g] = 1'b1;
        px[g] = 9'(v);
        p = pos[g];
        r = p / w;
        c = p % w;
        fbuf[g][p] = v;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = max4(fbuf[g][p], fbuf[g][p-1], fbuf[g][p-w], fbuf[g][p-w-1]);
            e.cyc = cyc + 1;
            e.fd  = (p == w * w - 1);
            if (g == 0) begin
                e.val = 9'(m);
                expq[0].push_back(e);
                e.val = 9'((m < 0) ? 0 : m);
                expq[1].push_back(e);
            end else begin
                e.val = 9'((m < 0) ? 0 : m);
                expq[2].push_back(e);
            end
        end
        pos[g] = (p + 1) % (w * w);
    endtask

    task automatic idle(int g, int n);
        repeat (n) begin
            @(posedge clk); #1;
            iv[g] = 1'b0;
        end
    endtask

    task automatic send(int g, int maxgap);
        foreach (frame[k])
            drive(g, frame[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        idle(g, 4);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            obs[i].delete();
            fdcnt[i] = 0;
        end
    endtask

    task automatic check_empty(string name);
        for (int i = 0; i < 3; i++)
            chk(expq[i].size() == 0, $sformatf("%s u%0d drained", name, i),
                expq[i].size(), 0);
    endtask

    task automatic expect_log(int i, string name);
        chk(obs[i].size() == ev.size(), {name, " count"}, obs[i].size(), ev.size());
        for (int k = 0; k < ev.size() && k < obs[i].size(); k++)
            chk(obs[i][k] == 9'(ev[k]), $sformatf("%s[%0d]", name, k),
                int'($signed(obs[i][k])), ev[k]);
    endtask

    task automatic check_reset_outputs(string name);
        chk(vld == 3'b000, {name, " valid"}, int'(vld), 0);
        chk(fdn == 3'b000, {name, " frame_done"}, int'(fdn), 0);
        for (int i = 0; i < 3; i++)
            chk(po[i] == 9'd0, $sformatf("%s pool_out u%0d", name, i),
                int'(po[i]), 0);
    endtask

    task automatic ramp_up();
        frame.delete();
        for (int k = 1; k <= 16; k++) frame.push_back(k);
    endtask

    initial begin
        pos[0] = 0;
        pos[1] = 0;
        clear_logs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #3;
        reset = 1'b0;

        // Back-to-back ramp frame.
        ramp_up();
        send(0, 0);
        ev = '{6, 8, 14, 16};
        expect_log(0, "ramp");
        expect_log(1, "ramp relu");
        chk(fdcnt[0] == 1, "ramp frame_done", fdcnt[0], 1);
        check_empty("ramp");

        // Same frame with random input gaps.
        clear_logs();
        send(0, 5);
        expect_log(0, "gaps");
        check_empty("gaps");

        // Negative values and extremes.
        clear_logs();
        frame = '{-3, -7, -256, 255, -1, -9, 0, -1};
        for (int k = 0; k < 8; k++) frame.push_back(int'($urandom_range(0, 511)) - 256);
        send(0, 0);
        chk(obs[0].size() == 4, "signed count", obs[0].size(), 4);
        if (obs[0].size() >= 2 && obs[1].size() >= 2) begin
            chk(obs[0][0] == 9'h1FF, "signed relu0 w0", int'(obs[0][0]), 'h1FF);
            chk(obs[1][0] == 9'h000, "signed relu1 w0", int'(obs[1][0]), 0);
            chk(obs[0][1] == 9'd255, "signed relu0 w1", int'(obs[0][1]), 255);
            chk(obs[1][1] == 9'd255, "signed relu1 w1", int'(obs[1][1]), 255);
        end
        check_empty("signed");

        // Asynchronous reset part-way through row 1.
        ramp_up();
        for (int k = 0; k < 6; k++) drive(0, frame[k], 0);
        idle(0, 3);
        check_empty("pre-reset");
        @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid reset a");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid reset b");
        @(posedge clk); #3;
        reset = 1'b0;
        pos[0] = 0;
        pos[1] = 0;
        clear_logs();
        send(0, 0);
        ev = '{6, 8, 14, 16};
        expect_log(0, "post reset");
        check_empty("post reset");

        // Two consecutive frames, second descending.
        clear_logs();
        ramp_up();
        for (int k = 16; k >= 1; k--) frame.push_back(k);
        send(0, 0);
        ev = '{6, 8, 14, 16, 16, 14, 8, 6};
        expect_log(0, "two frames");
        chk(fdcnt[0] == 2, "two frames frame_done", fdcnt[0], 2);
        check_empty("two frames");

        // Default 26x26 geometry with random signed samples.
        clear_logs();
        frame.delete();
        for (int k = 0; k < 676; k++) frame.push_back(int'($urandom_range(0, 511)) - 256);
        send(1, 1);
        chk(obs[2].size() == 169, "26x26 valid count", obs[2].size(), 169);
        chk(fdcnt[2] == 1, "26x26 frame_done", fdcnt[2], 1);
        check_empty("26x26");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
